// File: rtl/digit_window_scroller.sv
// -----------------------------------------------------------------------------
// digit_window_scroller
//
// Scrolling viewport over a row of NUM_DIGITS digit codes. WIN consecutive
// digits starting at a registered offset are presented on win_out. The offset
// moves one position per rising edge of step_up / step_dn, optionally repeating
// while a request is held, and either saturates or wraps at the ends of the
// meaningful range given by len.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   digits_in  NUM_DIGITS packed digit codes, digit k at [k*DIGIT_W +: DIGIT_W]
//   len        number of meaningful digits (0..NUM_DIGITS)
//   step_dn    level request to scroll toward digit 0
//   step_up    level request to scroll toward higher digits
//   home       force the offset to 0
//   win_out    registered window, slot i = digit (offset + i)
//   offset     current window start
//   at_min     offset == 0
//   at_max     offset == max_off
//
// Handshake: none. step_up/step_dn are plain levels; a step is taken on the
// cycle the level is first seen high (and on repeat ticks while held).
// -----------------------------------------------------------------------------
module digit_window_scroller #(
   parameter int DIGIT_W    = 4,
   parameter int NUM_DIGITS = 8,
   parameter int WIN        = 3,
   parameter int WRAP       = 0,
   parameter int REPEAT     = 0,
   localparam int OFF_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int LEN_W     = $clog2(NUM_DIGITS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
   input  logic [LEN_W-1:0]              len,
   input  logic                          step_dn,
   input  logic                          step_up,
   input  logic                          home,
   output logic [WIN*DIGIT_W-1:0]        win_out,
   output logic [OFF_W-1:0]              offset,
   output logic                          at_min,
   output logic                          at_max
);

   localparam bit WRAP_EN  = (WRAP != 0);
   localparam bit REP_EN   = (REPEAT > 0);
   localparam int CNT_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   // Counter value on the cycle a repeat step fires; the counter started at 0
   // on the edge cycle, so REPEAT-1 here means REPEAT held cycles after it.
   localparam int REP_LAST = REP_EN ? (REPEAT - 1) : 0;

   localparam logic [LEN_W-1:0] WIN_L = LEN_W'(WIN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REP_LAST);

   // ---------------------------------------------------------------------------
   // Largest legal offset for the current len
   // ---------------------------------------------------------------------------
   logic [OFF_W-1:0] max_off;

   always_comb begin
      max_off = '0;
      if (len > WIN_L) begin
         max_off = OFF_W'(len - WIN_L);
      end
   end

   assign at_min = (offset == '0);
   assign at_max = (offset == max_off);

   // ---------------------------------------------------------------------------
   // Request detection with optional hold-to-repeat
   // ---------------------------------------------------------------------------
   logic             step_up_q;
   logic             step_dn_q;
   // arm flags are set only by a genuine rising edge, so a level that survives
   // reset (previous-sample forced to 1) never starts repeating on its own.
   logic             up_arm;
   logic             dn_arm;
   logic [CNT_W-1:0] up_cnt;
   logic [CNT_W-1:0] dn_cnt;

   logic up_edge;
   logic dn_edge;
   logic up_held;
   logic dn_held;
   logic up_rep;
   logic dn_rep;
   logic up_evt;
   logic dn_evt;

   always_comb begin
      up_edge = step_up & ~step_up_q;
      dn_edge = step_dn & ~step_dn_q;
      up_held = step_up & step_up_q & up_arm;
      dn_held = step_dn & step_dn_q & dn_arm;
      up_rep  = REP_EN & up_held & (up_cnt == CNT_LAST);
      dn_rep  = REP_EN & dn_held & (dn_cnt == CNT_LAST);
      up_evt  = up_edge | up_rep;
      dn_evt  = dn_edge | dn_rep;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_up_q <= 1'b1;
         step_dn_q <= 1'b1;
         up_arm    <= 1'b0;
         dn_arm    <= 1'b0;
         up_cnt    <= '0;
         dn_cnt    <= '0;
      end else begin
         step_up_q <= step_up;
         step_dn_q <= step_dn;

         if (!step_up) begin
            up_arm <= 1'b0;
            up_cnt <= '0;
         end else if (up_edge) begin
            up_arm <= REP_EN;
            up_cnt <= '0;
         end else if (up_held) begin
            up_cnt <= up_rep ? '0 : up_cnt + 1'b1;
         end

         if (!step_dn) begin
            dn_arm <= 1'b0;
            dn_cnt <= '0;
         end else if (dn_edge) begin
            dn_arm <= REP_EN;
            dn_cnt <= '0;
         end else if (dn_held) begin
            dn_cnt <= dn_rep ? '0 : dn_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Offset update; events that lose to a higher priority are dropped
   // ---------------------------------------------------------------------------
   logic [OFF_W-1:0] off_nxt;

   always_comb begin
      off_nxt = offset;
      if (home) begin
         off_nxt = '0;
      end else if (offset > max_off) begin
         // len shrank under the window: pull it back inside the valid range
         off_nxt = max_off;
      end else if (up_evt && dn_evt) begin
         off_nxt = offset;
      end else if (up_evt) begin
         if (offset < max_off) begin
            off_nxt = offset + 1'b1;
         end else if (WRAP_EN) begin
            off_nxt = '0;
         end
      end else if (dn_evt) begin
         if (offset != '0) begin
            off_nxt = offset - 1'b1;
         end else if (WRAP_EN) begin
            off_nxt = max_off;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Window selection. Each slot is a mux over all digit positions so that
   // slots running past the end of the row simply select nothing and read 0.
   // ---------------------------------------------------------------------------
   logic [WIN*DIGIT_W-1:0] win_nxt;

   always_comb begin
      win_nxt = '0;
      for (int i = 0; i < WIN; i++) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(offset) + i == k) begin
               win_nxt[i*DIGIT_W +: DIGIT_W] = digits_in[k*DIGIT_W +: DIGIT_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         offset  <= '0;
         win_out <= '0;
      end else begin
         offset  <= off_nxt;
         win_out <= win_nxt;
      end
   end

endmodule

// File: tb/tb_digit_window_scroller.sv
// -----------------------------------------------------------------------------
// tb_digit_window_scroller
//
// Three scroller instances share clk/rst:
//   a: 5 digits, saturating, no repeat
//   b: 5 digits, wrapping,   no repeat
//   c: 8 digits, saturating, repeat every 4 cycles
// Directed steps in one initial block; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_digit_window_scroller;

   logic clk;
   logic rst;

   // instance a
   logic [19:0] a_digits;
   logic [2:0]  a_len;
   logic        a_up, a_dn, a_home;
   logic [11:0] a_win;
   logic [2:0]  a_off;
   logic        a_min, a_max;

   // instance b
   logic [19:0] b_digits;
   logic [2:0]  b_len;
   logic        b_up, b_dn, b_home;
   logic [11:0] b_win;
   logic [2:0]  b_off;
   logic        b_min, b_max;

   // instance c
   logic [31:0] c_digits;
   logic [3:0]  c_len;
   logic        c_up, c_dn, c_home;
   logic [11:0] c_win;
   logic [2:0]  c_off;
   logic        c_min, c_max;

   int n_checks;
   int n_errors;

   digit_window_scroller #(
      .DIGIT_W(4), .NUM_DIGITS(5), .WIN(3), .WRAP(0), .REPEAT(0)
   ) u_a (
      .clk(clk), .rst(rst), .digits_in(a_digits), .len(a_len),
      .step_dn(a_dn), .step_up(a_up), .home(a_home),
      .win_out(a_win), .offset(a_off), .at_min(a_min), .at_max(a_max)
   );

   digit_window_scroller #(
      .DIGIT_W(4), .NUM_DIGITS(5), .WIN(3), .WRAP(1), .REPEAT(0)
   ) u_b (
      .clk(clk), .rst(rst), .digits_in(b_digits), .len(b_len),
      .step_dn(b_dn), .step_up(b_up), .home(b_home),
      .win_out(b_win), .offset(b_off), .at_min(b_min), .at_max(b_max)
   );

   digit_window_scroller #(
      .DIGIT_W(4), .NUM_DIGITS(8), .WIN(3), .WRAP(0), .REPEAT(4)
   ) u_c (
      .clk(clk), .rst(rst), .digits_in(c_digits), .len(c_len),
      .step_dn(c_dn), .step_up(c_up), .home(c_home),
      .win_out(c_win), .offset(c_off), .at_min(c_min), .at_max(c_max)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance n rising edges; return 1 time unit after the last one so that
   // outputs are sampled and inputs driven away from the edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      a_digits = 20'h54321; a_len = 3'd5; a_up = 0; a_dn = 0; a_home = 0;
      b_digits = 20'h54321; b_len = 3'd5; b_up = 0; b_dn = 0; b_home = 0;
      c_digits = 32'h87654321; c_len = 4'd8; c_up = 0; c_dn = 0; c_home = 0;

      // ---------------- reset ----------------
      tick(2);
      check("rst_a_off", a_off, 0);
      check("rst_a_win", a_win, 0);
      check("rst_a_min", a_min, 1);
      check("rst_a_max", a_max, 0);
      check("rst_c_win", c_win, 0);
      rst = 1'b0;
      tick();
      check("a_win_after_rst", a_win, 12'h321);
      check("a_off_after_rst", a_off, 0);
      check("a_min_after_rst", a_min, 1);

      // ---------------- single pulse, latency ----------------
      a_up = 1; tick(); a_up = 0;
      check("a_pulse_off_e1", a_off, 1);
      check("a_pulse_win_e1", a_win, 12'h321);
      tick();
      check("a_pulse_win_e2", a_win, 12'h432);
      check("a_pulse_min", a_min, 0);

      // ---------------- held level gives one step ----------------
      a_home = 1; tick(); a_home = 0;
      check("a_home_off", a_off, 0);
      a_up = 1; tick(10); a_up = 0;
      check("a_hold_off", a_off, 1);
      tick();
      a_up = 1; tick(); a_up = 0; tick();
      a_up = 1; tick(); a_up = 0; tick();
      check("a_sat_off", a_off, 2);
      check("a_sat_win", a_win, 12'h543);
      check("a_sat_max", a_max, 1);
      a_up = 1; tick(); a_up = 0; tick();
      check("a_sat_hold_off", a_off, 2);

      // ---------------- len shrink clamps ----------------
      a_len = 3'd3; tick();
      check("a_shrink_off", a_off, 0);
      check("a_shrink_min", a_min, 1);
      check("a_shrink_max", a_max, 1);
      a_len = 3'd5;
      a_up = 1; tick(); a_up = 0; tick();
      check("a_regrow_off", a_off, 1);
      a_home = 1; a_up = 1; tick(); a_home = 0; a_up = 0;
      check("a_home_beats_up", a_off, 0);
      tick();

      // ---------------- step down, saturate at 0 ----------------
      a_up = 1; tick(); a_up = 0; tick();
      a_dn = 1; tick(); a_dn = 0; tick();
      check("a_dn_off", a_off, 0);
      a_dn = 1; tick(); a_dn = 0; tick();
      check("a_dn_sat_off", a_off, 0);

      // ---------------- digits_in latency ----------------
      a_digits = 20'hABCDE; tick();
      check("a_digits_lat", a_win, 12'hCDE);

      // ---------------- wrap mode ----------------
      b_up = 1; tick(); b_up = 0; tick();
      b_up = 1; tick(); b_up = 0; tick();
      check("b_to_max", b_off, 2);
      b_up = 1; tick(); b_up = 0; tick();
      check("b_wrap_up", b_off, 0);
      b_dn = 1; tick(); b_dn = 0; tick();
      check("b_wrap_dn", b_off, 2);
      b_up = 1; b_dn = 1; tick(); b_up = 0; b_dn = 0;
      check("b_both_hold", b_off, 2);
      tick();
      b_dn = 1; tick(); b_dn = 0; tick();
      check("b_dn_mid", b_off, 1);
      b_len = 3'd3; tick();
      check("b_shrink", b_off, 0);
      b_up = 1; tick(); b_up = 0; tick();
      check("b_wrap_zero_range", b_off, 0);
      check("b_wrap_zero_max", b_max, 1);

      // ---------------- repeat ----------------
      c_up = 1;
      tick();
      check("c_rep_edge", c_off, 1);
      tick(3);
      check("c_rep_before", c_off, 1);
      tick();
      check("c_rep_first", c_off, 2);
      tick(8);
      check("c_rep_13", c_off, 4);
      c_up = 0; tick();
      check("c_release", c_off, 4);
      c_up = 1; tick(); c_up = 0;
      check("c_repress_off", c_off, 5);
      check("c_repress_max", c_max, 1);
      tick();
      check("c_repress_win", c_win, 12'h876);

      // ---------------- reset in the middle of a hold ----------------
      c_home = 1; tick(); c_home = 0;
      check("c_home", c_off, 0);
      c_up = 1; tick(3);
      check("c_hold_pre_rst", c_off, 1);
      rst = 1; tick();
      check("c_rst_off", c_off, 0);
      check("c_rst_win", c_win, 0);
      rst = 0; tick(9);
      check("c_no_step_after_rst", c_off, 0);
      check("c_win_after_rst", c_win, 12'h321);
      c_up = 0; tick();
      c_up = 1; tick(); c_up = 0;
      check("c_step_after_release", c_off, 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
